pixel_fb_writer: RTL and testbench

Sits directly downstream of the box/clear drawing engine. It consumes that engine's pixel stream (X, Y, colour, plot strobe) and buffers it in a small FIFO. Each buffered pixel becomes a linear frame-buffer address, and the block issues one write per pixel to the frame-buffer RAM write port. The RAM port can be stalled by scan-out arbitration; the FIFO absorbs those stalls so the drawing engine only sees backpressure when the FIFO is full.

---
 rtl/pixel_fb_writer_pkg.sv | 34 +++
 rtl/pixel_fifo.sv | 58 +++++
 rtl/pixel_fb_writer.sv | 105 ++++++++++
 tb/tb_pixel_fb_writer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_fb_writer_pkg.sv
// Frame-buffer geometry, widths and the xy-to-address helper shared by
// the drawing engine, this writer and VGA scan-out.
package pixel_fb_writer_pkg;

   localparam int SCREEN_W  = 160;
   localparam int SCREEN_H  = 120;
   localparam int FB_ADDR_W = 15;
   localparam int COLOUR_W  = 3;
   localparam int X_W       = 8;
   localparam int Y_W       = 7;

   typedef logic [FB_ADDR_W-1:0] fb_addr_t;
   typedef logic [COLOUR_W-1:0]  colour_t;

   typedef struct packed {
      fb_addr_t addr;
      colour_t  colour;
   } fb_px_t;

   localparam int PX_W = $bits(fb_px_t);

   // Y*160 + X built from shifts so no multiplier is needed.
   function automatic fb_addr_t xy_to_addr(
      input logic [X_W-1:0] x,
      input logic [Y_W-1:0] y
   );
      fb_addr_t w_y;
      fb_addr_t w_x;
      w_y = {{(FB_ADDR_W-Y_W){1'b0}}, y};
      w_x = {{(FB_ADDR_W-X_W){1'b0}}, x};
      return (w_y << 7) + (w_y << 5) + w_x;
   endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with registered count; read data is the head entry,
// valid whenever the FIFO is not empty.
module pixel_fifo #(
   parameter  int WIDTH = 18,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [CW-1:0]    o_count
);

   localparam logic [CW-1:0] LP_FULL = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == LP_FULL);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_rdata = r_mem[r_rd_ptr];

   assign w_push = i_push & ~o_full;
   assign w_pop  = i_pop & ~o_empty;

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/pixel_fb_writer.sv
// Buffers the drawing engine's pixel stream and issues one frame-buffer
// write per on-screen pixel, absorbing RAM-port stalls in a FIFO.
module pixel_fb_writer
   import pixel_fb_writer_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int SCREEN_W   = pixel_fb_writer_pkg::SCREEN_W,
   parameter int SCREEN_H   = pixel_fb_writer_pkg::SCREEN_H
) (
   input  logic                 iClock,
   input  logic                 iResetn,
   input  logic [X_W-1:0]       iX,
   input  logic [Y_W-1:0]       iY,
   input  logic [COLOUR_W-1:0]  iColour,
   input  logic                 iPlot,
   output logic                 oReady,
   input  logic                 iMemBusy,
   output logic [FB_ADDR_W-1:0] oWrAddr,
   output logic [COLOUR_W-1:0]  oWrData,
   output logic                 oWrEn,
   output logic                 oIdle,
   output logic                 oOverflow,
   output logic [7:0]           oClipCount
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [X_W-1:0] LP_W = X_W'(SCREEN_W);
   localparam logic [Y_W-1:0] LP_H = Y_W'(SCREEN_H);

   logic          w_full;
   logic          w_empty;
   logic [CW-1:0] w_count;
   fb_px_t        w_in_px;
   fb_px_t        w_head_px;
   logic          w_accept;
   logic          w_on_screen;
   logic          w_push;
   logic          w_clip;
   logic          w_pop;

   logic          r_wr_en;
   fb_addr_t      r_wr_addr;
   colour_t       r_wr_data;
   logic          r_overflow;
   logic [7:0]    r_clip_count;

   assign oReady      = iResetn & ~w_full;
   assign w_accept    = iPlot & oReady;
   assign w_on_screen = (iX < LP_W) & (iY < LP_H);
   assign w_push      = w_accept & w_on_screen;
   assign w_clip      = w_accept & ~w_on_screen;
   assign w_pop       = ~w_empty & ~iMemBusy;

   assign w_in_px.addr   = xy_to_addr(iX, iY);
   assign w_in_px.colour = iColour;

   pixel_fifo #(
      .WIDTH (PX_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (iClock),
      .i_rst_n (iResetn),
      .i_push  (w_push),
      .i_wdata (w_in_px),
      .i_pop   (w_pop),
      .o_rdata (w_head_px),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // Output stage: address/data hold their last value between writes.
   always_ff @(posedge iClock) begin
      if (!iResetn) begin
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         r_wr_en <= w_pop;
         if (w_pop) begin
            r_wr_addr <= w_head_px.addr;
            r_wr_data <= w_head_px.colour;
         end
      end
   end

   always_ff @(posedge iClock) begin
      if (!iResetn) begin
         r_overflow   <= 1'b0;
         r_clip_count <= '0;
      end else begin
         if (iPlot & w_full) r_overflow <= 1'b1;
         if (w_clip && r_clip_count != 8'hFF)
            r_clip_count <= r_clip_count + 8'd1;
      end
   end

   assign oWrEn      = r_wr_en;
   assign oWrAddr    = r_wr_addr;
   assign oWrData    = r_wr_data;
   assign oOverflow  = r_overflow;
   assign oClipCount = r_clip_count;
   assign oIdle      = (w_count == '0) & ~r_wr_en;

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Scoreboard bench: accepted on-screen pixels queue their expected write,
// a monitor pops and compares every oWrEn cycle.
module tb_pixel_fb_writer;

   logic        iClock   = 1'b0;
   logic        iResetn  = 1'b0;
   logic [7:0]  iX       = '0;
   logic [6:0]  iY       = '0;
   logic [2:0]  iColour  = '0;
   logic        iPlot    = 1'b0;
   logic        iMemBusy = 1'b0;
   logic        oReady;
   logic [14:0] oWrAddr;
   logic [2:0]  oWrData;
   logic        oWrEn;
   logic        oIdle;
   logic        oOverflow;
   logic [7:0]  oClipCount;

   always #5 iClock = ~iClock;

   pixel_fb_writer dut (
      .iClock     (iClock),
      .iResetn    (iResetn),
      .iX         (iX),
      .iY         (iY),
      .iColour    (iColour),
      .iPlot      (iPlot),
      .oReady     (oReady),
      .iMemBusy   (iMemBusy),
      .oWrAddr    (oWrAddr),
      .oWrData    (oWrData),
      .oWrEn      (oWrEn),
      .oIdle      (oIdle),
      .oOverflow  (oOverflow),
      .oClipCount (oClipCount)
   );

   typedef struct {
      int addr;
      int col;
   } exp_t;

   exp_t exp_q[$];
   exp_t m_e;
   int   wr_cyc[$];
   int   n_tests  = 0;
   int   n_fail   = 0;
   int   n_wr     = 0;
   int   cyc      = 0;
   bit   tog_en   = 0;
   bit   rnd_busy = 0;

   task automatic check(input string nm, input int got, input int want);
      n_tests++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, got, want, $time);
      end
   endtask

   always @(posedge iClock) cyc <= cyc + 1;

   always @(negedge iClock) begin
      if (oWrEn === 1'b1) begin
         n_wr++;
         wr_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %0d data %0d, want none",
                     oWrAddr, oWrData);
         end else begin
            m_e = exp_q.pop_front();
            check("wr_addr", int'(oWrAddr), m_e.addr);
            check("wr_data", int'(oWrData), m_e.col);
         end
      end
   end

   // Producer: optionally waits for oReady, presents the pixel for one edge.
   task automatic drive(input int x, input int y, input int c,
                        input bit honour, output bit acc, output int waited);
      waited = 0;
      @(negedge iClock);
      if (honour)
         while (oReady !== 1'b1 && waited < 100) begin
            @(negedge iClock);
            waited++;
         end
      if (waited >= 100) check("ready_timeout", 0, 1);
      acc     = (oReady === 1'b1);
      iX      = x[7:0];
      iY      = y[6:0];
      iColour = c[2:0];
      iPlot   = 1'b1;
      @(posedge iClock);
      #1;
      iPlot = 1'b0;
      if (acc && x < 160 && y < 120)
         exp_q.push_back('{x + y * 160, c});
   endtask

   task automatic wait_idle();
      int t = 0;
      @(negedge iClock);
      while (!(oIdle === 1'b1 && exp_q.size() == 0) && t < 500) begin
         @(negedge iClock);
         t++;
      end
      check("idle_timeout", int'(t < 500), 1);
   endtask

   task automatic do_reset();
      iResetn  = 1'b0;
      iPlot    = 1'b0;
      iMemBusy = 1'b0;
      repeat (2) @(posedge iClock);
      #1;
      exp_q.delete();
      iResetn = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit acc;
      int w;
      int base;
      int x;
      int y;
      int n_clip;

      // 1: reset values, single pixel latency
      repeat (2) @(posedge iClock);
      @(negedge iClock);
      check("rst_wren",     int'(oWrEn), 0);
      check("rst_addr",     int'(oWrAddr), 0);
      check("rst_data",     int'(oWrData), 0);
      check("rst_overflow", int'(oOverflow), 0);
      check("rst_clip",     int'(oClipCount), 0);
      check("rst_idle",     int'(oIdle), 1);
      check("rst_ready",    int'(oReady), 0);
      @(posedge iClock);
      #1;
      iResetn = 1'b1;
      @(negedge iClock);
      check("ready_after_rst", int'(oReady), 1);
      @(posedge iClock);
      #1;
      base = n_wr;
      drive(5, 3, 4, 1, acc, w);
      @(negedge iClock);
      check("t1_wren_n1", int'(oWrEn), 0);
      @(negedge iClock);
      check("t1_wren_n2", int'(oWrEn), 1);
      check("t1_addr", int'(oWrAddr), 485);
      check("t1_data", int'(oWrData), 4);
      @(negedge iClock);
      check("t1_wren_n3", int'(oWrEn), 0);
      check("t1_idle", int'(oIdle), 1);
      check("t1_writes", n_wr - base, 1);

      // 2: 4x4 box behind a busy RAM port
      do_reset();
      iMemBusy = 1'b1;
      base = n_wr;
      wr_cyc.delete();
      for (int i = 0; i < 8; i++) begin
         drive(10 + i % 4, 20 + i / 4, i % 8, 1, acc, w);
         check("t2_no_wait", w, 0);
      end
      @(negedge iClock);
      check("t2_ready_full", int'(oReady), 0);
      check("t2_no_writes", n_wr - base, 0);
      check("t2_not_idle", int'(oIdle), 0);
      iMemBusy = 1'b0;
      for (int i = 8; i < 16; i++)
         drive(10 + i % 4, 20 + i / 4, (i * 3) % 8, 1, acc, w);
      wait_idle();
      check("t2_writes", n_wr - base, 16);
      if (wr_cyc.size() == 16)
         check("t2_back_to_back", wr_cyc[15] - wr_cyc[0], 15);
      check("t2_overflow", int'(oOverflow), 0);

      // 3: screen boundary and clip saturation
      do_reset();
      base = n_wr;
      drive(159, 119, 6, 1, acc, w);
      drive(160, 0, 1, 1, acc, w);
      drive(0, 120, 2, 1, acc, w);
      wait_idle();
      check("t3_writes", n_wr - base, 1);
      check("t3_clip", int'(oClipCount), 2);
      check("t3_ready", int'(oReady), 1);
      for (int i = 0; i < 258; i++)
         drive(160 + $urandom_range(0, 95), $urandom_range(0, 127), 0, 1, acc, w);
      @(negedge iClock);
      check("t3_clip_sat", int'(oClipCount), 255);
      check("t3_sat_writes", n_wr - base, 1);

      // 4: overflow on a full FIFO
      do_reset();
      iMemBusy = 1'b1;
      base = n_wr;
      for (int i = 0; i < 8; i++)
         drive(i, i, i, 1, acc, w);
      drive(50, 50, 7, 0, acc, w);
      check("t4_extra_rejected", int'(acc), 0);
      @(negedge iClock);
      check("t4_overflow_set", int'(oOverflow), 1);
      iMemBusy = 1'b0;
      wait_idle();
      check("t4_writes", n_wr - base, 8);
      check("t4_overflow_sticky", int'(oOverflow), 1);

      // 5: toggling busy, then random busy with clipped pixels mixed in
      do_reset();
      base = n_wr;
      tog_en = 1;
      fork
         begin
            while (tog_en) begin
               @(posedge iClock);
               #1;
               iMemBusy = rnd_busy ? 1'($urandom_range(0, 1)) : ~iMemBusy;
            end
         end
      join_none
      for (int i = 0; i < 20; i++)
         drive($urandom_range(0, 159), $urandom_range(0, 119),
               $urandom_range(0, 7), 1, acc, w);
      wait_idle();
      check("t5_writes", n_wr - base, 20);
      rnd_busy = 1;
      base = n_wr;
      n_clip = 0;
      for (int i = 0; i < 150; i++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge iClock);
            #1;
         end
         x = $urandom_range(0, 175);
         y = $urandom_range(0, 127);
         drive(x, y, $urandom_range(0, 7), 1, acc, w);
         if (acc && (x >= 160 || y >= 120)) n_clip++;
      end
      wait_idle();
      check("t5b_pending", exp_q.size(), 0);
      check("t5b_clip", int'(oClipCount), n_clip > 255 ? 255 : n_clip);
      check("t5b_overflow", int'(oOverflow), 0);
      tog_en = 0;
      @(posedge iClock);
      #2;
      iMemBusy = 1'b0;
      rnd_busy = 0;

      // 6: reset with entries queued
      do_reset();
      iMemBusy = 1'b1;
      drive(200, 0, 1, 1, acc, w);
      for (int i = 0; i < 5; i++)
         drive(30 + i, 40, i, 1, acc, w);
      @(negedge iClock);
      check("t6_clip_pre", int'(oClipCount), 1);
      iResetn = 1'b0;
      @(posedge iClock);
      #1;
      check("t6_wren", int'(oWrEn), 0);
      check("t6_idle", int'(oIdle), 1);
      check("t6_clip", int'(oClipCount), 0);
      check("t6_overflow", int'(oOverflow), 0);
      exp_q.delete();
      iMemBusy = 1'b0;
      iResetn  = 1'b1;
      base = n_wr;
      repeat (10) @(negedge iClock);
      check("t6_no_stale", n_wr - base, 0);
      check("t6_idle_after", int'(oIdle), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
